lcd_nibble_writer: RTL and testbench
====================================

# lcd_nibble_writer

Downstream consumer of the core's character output, driving the Spartan-3E 16x2 character LCD over its 4-bit bus. Accepts one byte per handshake (command or data), splits it into two nibbles, and generates the E-strobe, setup and inter-command waits. With init compiled in, it also runs the HD44780 power-on sequence itself. It replaces ad-hoc LCD sequencing inside the core.

## Interface
- POWERUP_WAIT, 750000: cycles from reset release to first init nibble (15 ms @ 50 MHz)
- E_SETUP, 2: cycles RS/data valid before E rises
- E_WIDTH, 12: cycles E held high
- NIBBLE_GAP, 50: cycles from E fall to next nibble setup, within one byte
- BYTE_WAIT, 2000: cycles after the low nibble's E falls before oReady (40 µs)
- CLEAR_WAIT, 82000: replaces BYTE_WAIT for command 0x01/0x02/0x03 (1.64 ms)
- Clock  in  1  system clock. All state changes on posedge.
- Reset  in  1  synchronous, active-high
- iWrite  in  1  byte request. Sampled only when oReady=1.
- iRS  in  1  0 = command, 1 = data. Captured with iWrite.
- iData  in  8  byte. Captured with iWrite.
- oReady  out  1  idle, accepts a byte
- oLCD_Enabled  out  1  LCD E
- oLCD_RegisterSelect  out  1  LCD RS
- oLCD_ReadWrite  out  1  fixed 0 (write only)
- oLCD_StrataFlashControl  out  1  fixed 1 (StrataFlash off the shared bus)
- oLCD_Data  out  4  LCD DB[7:4]

## Operation
- Reset values: oReady=0, E=0, RS=0, Data=0, RW=0, SF=1, counter=0, state=PWR_WAIT. Without init compiled in, state=IDLE.
- Reset applied mid-operation aborts the transfer. E=0 from the next edge. Any byte already captured is discarded.
- States:
  - PWR_WAIT → INIT_NIB after POWERUP_WAIT cycles.
  - INIT_NIB sends single nibbles 0x3, 0x3, 0x3, 0x2. Wait after each E fall: 205000, 5000, 2000, 2000 cycles.
  - INIT_CMD sends full bytes RS=0 0x28, 0x06, 0x0C, 0x01 through the normal byte path. The last byte uses CLEAR_WAIT.
  - Then IDLE.
- IDLE: oReady=1. iWrite=1 captures {iRS, iData} and moves to HI_SETUP. oReady=0 from the next cycle.
- HI_SETUP (E_SETUP cycles) → HI_PULSE (E=1, E_WIDTH cycles) → HI_GAP (NIBBLE_GAP cycles) → LO_SETUP → LO_PULSE → LO_WAIT → IDLE.
- oLCD_Data = byte[7:4] from HI_SETUP through HI_GAP, and byte[3:0] from LO_SETUP through LO_WAIT. RS is held from capture through LO_WAIT.
- LO_WAIT length = CLEAR_WAIT if RS=0 and byte ∈ {0x01,0x02,0x03}, else BYTE_WAIT.
- iWrite while oReady=0 is ignored. There is no queue, so the upstream side must hold or retry.
- One shared down-counter of 20 bits. All parameters must be < 2^20. A parameter value of 0 is treated as 1.

## Timing
- Capture edge = T0. E rises at T0+1+E_SETUP.
- High-nibble E falls at T0+1+E_SETUP+E_WIDTH.
- Low-nibble E rises NIBBLE_GAP+E_SETUP cycles after the high-nibble E fall.
- oReady returns BYTE_WAIT (or CLEAR_WAIT) cycles after the low-nibble E falls.
- Default byte throughput: 2+12+50+2+12+2000 = 2078 cycles + 1 capture cycle.
- Data and RS are stable for the whole E-high window and ≥1 cycle after E falls.
- iWrite on the same edge that oReady rises is not accepted. Acceptance requires oReady=1 before that edge.

## Configuration
- LCD_INIT_EN defined: the power-on sequence runs after every reset. oReady first rises after the init clear's CLEAR_WAIT completes.
- LCD_INIT_EN undefined: PWR_WAIT, INIT_NIB and INIT_CMD are removed. oReady=1 on the first cycle after Reset deasserts, and upstream software performs the init.

## Test plan
- Test parameters: POWERUP_WAIT=20, BYTE_WAIT=30, CLEAR_WAIT=60, NIBBLE_GAP=5; E_SETUP and E_WIDTH at defaults.
- Init check (LCD_INIT_EN): release Reset → E pulses carry nibbles 3,3,3,2,2,8,0,6,0,C,0,1, all with RS=0. oReady rises 60 cycles after the last E fall.
- Data write: iWrite, iRS=1, iData=0x41 → nibbles 0x4 then 0x1 with RS=1, E high 12 cycles each. oReady=0 for exactly 2078-cycle-scaled count (2+12+5+2+12+30+1).
- Clear timing: RS=0, 0x01 → LO_WAIT=60 cycles. A second run with RS=0, 0x80 → LO_WAIT=30 cycles.
- Busy drop: pulse iWrite with 0x55 while busy with 0x41 → only 4,1 appear on the bus, and no 5,5 follows.
- Reset mid-byte: assert Reset during HI_PULSE → E=0 next cycle and all outputs at their reset values. Without LCD_INIT_EN, oReady=1 one cycle after Reset deasserts.
- Back-to-back: hold iWrite high with 0x48 then 0x49 → the second byte is captured only on the edge after oReady is observed high.

Source files
------------

// File: rtl/lcd_nibble_writer.sv
// Byte-to-nibble writer for the 4-bit HD44780 bus (E strobe, setup and command waits).
// Define LCD_INIT_EN to run the power-on init sequence after every reset.
module lcd_nibble_writer #(
  parameter int unsigned POWERUP_WAIT = 750000,
  parameter int unsigned E_SETUP      = 2,
  parameter int unsigned E_WIDTH      = 12,
  parameter int unsigned NIBBLE_GAP   = 50,
  parameter int unsigned BYTE_WAIT    = 2000,
  parameter int unsigned CLEAR_WAIT   = 82000,
  parameter int unsigned INIT_WAIT0   = 205000,
  parameter int unsigned INIT_WAIT1   = 5000,
  parameter int unsigned INIT_WAIT2   = 2000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iWrite,
  input  logic       iRS,
  input  logic [7:0] iData,
  output logic       oReady,
  output logic       oLCD_Enabled,
  output logic       oLCD_RegisterSelect,
  output logic       oLCD_ReadWrite,
  output logic       oLCD_StrataFlashControl,
  output logic [3:0] oLCD_Data
);

  if (POWERUP_WAIT >= 2**20 || E_SETUP >= 2**20 || E_WIDTH >= 2**20 ||
      NIBBLE_GAP >= 2**20 || BYTE_WAIT >= 2**20 || CLEAR_WAIT >= 2**20 ||
      INIT_WAIT0 >= 2**20 || INIT_WAIT1 >= 2**20 || INIT_WAIT2 >= 2**20) begin : gParamRange
    $error("lcd_nibble_writer: timing parameters must be below 2^20");
  end

  typedef enum logic [3:0] {
`ifdef LCD_INIT_EN
    PWR_WAIT,
    INIT_NIB,
    INIT_CMD,
`endif
    IDLE,
    HI_SETUP,
    HI_PULSE,
    HI_GAP,
    LO_SETUP,
    LO_PULSE,
    LO_WAIT
  } state_e;

`ifdef LCD_INIT_EN
  localparam state_e RESET_STATE = PWR_WAIT;
`else
  localparam state_e RESET_STATE = IDLE;
`endif

  // Counter load for an N-cycle phase; 0 behaves as 1.
  function automatic logic [19:0] ld(input int unsigned p);
    return (p == 0) ? '0 : 20'(p - 1);
  endfunction

  // One extra setup cycle accounts for the capture cycle ahead of E.
  localparam logic [19:0] SETUP_LOAD = ld(E_SETUP) + 20'd1;

  state_e      state, stateNext;
  logic [19:0] cnt, cntNext;
  logic [7:0]  byteReg, byteNext;
  logic        rsReg, rsNext;
  logic        readyNext, eNext, rsOutNext;
  logic [3:0]  dataNext;
  logic        cntZero, isClear;

`ifdef LCD_INIT_EN
  logic [2:0]  step, stepNext;
  logic        initDone, initDoneNext;
  logic        armed, armedNext;
  logic        nibOnly;
  logic [3:0]  initNib;
  logic [7:0]  initCmd;
  logic [19:0] initWait;

  assign nibOnly  = !initDone && !step[2];
  assign initNib  = (step[1:0] == 2'd3) ? 4'h2 : 4'h3;
  assign initWait = (step[1:0] == 2'd0) ? ld(INIT_WAIT0) :
                    (step[1:0] == 2'd1) ? ld(INIT_WAIT1) : ld(INIT_WAIT2);

  always_comb begin
    unique case (step[1:0])
      2'd0:    initCmd = 8'h28;
      2'd1:    initCmd = 8'h06;
      2'd2:    initCmd = 8'h0C;
      default: initCmd = 8'h01;
    endcase
  end
`endif

  assign cntZero = (cnt == '0);
  assign isClear = !rsReg && (byteReg inside {8'h01, 8'h02, 8'h03});

  assign oLCD_ReadWrite          = 1'b0;
  assign oLCD_StrataFlashControl = 1'b1;

  always_comb begin
    stateNext = state;
    cntNext   = cnt - 20'd1;
    byteNext  = byteReg;
    rsNext    = rsReg;
`ifdef LCD_INIT_EN
    stepNext     = step;
    initDoneNext = initDone;
    armedNext    = armed;
`endif
    unique case (state)
`ifdef LCD_INIT_EN
      PWR_WAIT: begin
        if (!armed) begin
          armedNext = 1'b1;
          cntNext   = ld(POWERUP_WAIT);
        end else if (cntZero) begin
          stateNext = INIT_NIB;
        end
      end
      // Init nibbles reuse the high-nibble path with both halves equal.
      INIT_NIB: begin
        byteNext  = {initNib, initNib};
        rsNext    = 1'b0;
        stateNext = HI_SETUP;
        cntNext   = SETUP_LOAD;
      end
      INIT_CMD: begin
        byteNext  = initCmd;
        rsNext    = 1'b0;
        stateNext = HI_SETUP;
        cntNext   = SETUP_LOAD;
      end
`endif
      IDLE: begin
        cntNext = cnt;
        if (oReady && iWrite) begin
          byteNext  = iData;
          rsNext    = iRS;
          stateNext = HI_SETUP;
          cntNext   = SETUP_LOAD;
        end
      end
      HI_SETUP: if (cntZero) begin
        stateNext = HI_PULSE;
        cntNext   = ld(E_WIDTH);
      end
      HI_PULSE: if (cntZero) begin
        stateNext = HI_GAP;
        cntNext   = ld(NIBBLE_GAP);
`ifdef LCD_INIT_EN
        if (nibOnly) begin
          stateNext = LO_WAIT;
          cntNext   = initWait;
        end
`endif
      end
      HI_GAP: if (cntZero) begin
        stateNext = LO_SETUP;
        cntNext   = ld(E_SETUP);
      end
      LO_SETUP: if (cntZero) begin
        stateNext = LO_PULSE;
        cntNext   = ld(E_WIDTH);
      end
      LO_PULSE: if (cntZero) begin
        stateNext = LO_WAIT;
        cntNext   = isClear ? ld(CLEAR_WAIT) : ld(BYTE_WAIT);
      end
      LO_WAIT: if (cntZero) begin
        stateNext = IDLE;
        cntNext   = '0;
`ifdef LCD_INIT_EN
        if (!initDone) begin
          stepNext = step + 3'd1;
          if (step == 3'd7)      initDoneNext = 1'b1;
          else if (step < 3'd3)  stateNext = INIT_NIB;
          else                   stateNext = INIT_CMD;
        end
`endif
      end
      default: begin
        stateNext = IDLE;
        cntNext   = '0;
      end
    endcase

    // Bus outputs are registered from the next state so they align with it.
    readyNext = (stateNext == IDLE);
    eNext     = stateNext inside {HI_PULSE, LO_PULSE};
    dataNext  = oLCD_Data;
    rsOutNext = oLCD_RegisterSelect;
    if (stateNext inside {HI_SETUP, HI_PULSE, HI_GAP}) begin
      dataNext  = byteNext[7:4];
      rsOutNext = rsNext;
    end else if (stateNext inside {LO_SETUP, LO_PULSE, LO_WAIT}) begin
      dataNext  = byteNext[3:0];
      rsOutNext = rsNext;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state               <= RESET_STATE;
      cnt                 <= '0;
      byteReg             <= '0;
      rsReg               <= 1'b0;
      oReady              <= 1'b0;
      oLCD_Enabled        <= 1'b0;
      oLCD_RegisterSelect <= 1'b0;
      oLCD_Data           <= '0;
`ifdef LCD_INIT_EN
      step                <= '0;
      initDone            <= 1'b0;
      armed               <= 1'b0;
`endif
    end else begin
      state               <= stateNext;
      cnt                 <= cntNext;
      byteReg             <= byteNext;
      rsReg               <= rsNext;
      oReady              <= readyNext;
      oLCD_Enabled        <= eNext;
      oLCD_RegisterSelect <= rsOutNext;
      oLCD_Data           <= dataNext;
`ifdef LCD_INIT_EN
      step                <= stepNext;
      initDone            <= initDoneNext;
      armed               <= armedNext;
`endif
    end
  end

endmodule

// File: tb/tb_lcd_nibble_writer.sv
// Directed bench for lcd_nibble_writer: records every E pulse and checks nibbles and waits.
module tb_lcd_nibble_writer;

  localparam int unsigned PW = 20;
  localparam int unsigned BW = 30;
  localparam int unsigned CW = 60;
  localparam int unsigned NG = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       iWrite = 1'b0;
  logic       iRS = 1'b0;
  logic [7:0] iData = 8'h00;
  logic       oReady, oE, oRS, oRW, oSF;
  logic [3:0] oD;

  int tests = 0;
  int failed = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  lcd_nibble_writer #(
    .POWERUP_WAIT(PW),
    .BYTE_WAIT(BW),
    .CLEAR_WAIT(CW),
    .NIBBLE_GAP(NG),
    .INIT_WAIT0(40),
    .INIT_WAIT1(20),
    .INIT_WAIT2(10)
  ) dut (
    .Clock(clk),
    .Reset(rst),
    .iWrite(iWrite),
    .iRS(iRS),
    .iData(iData),
    .oReady(oReady),
    .oLCD_Enabled(oE),
    .oLCD_RegisterSelect(oRS),
    .oLCD_ReadWrite(oRW),
    .oLCD_StrataFlashControl(oSF),
    .oLCD_Data(oD)
  );

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] nib;
    logic       rs;
    int         width;
    int         rise;
    int         fall;
  } pulse_t;

  pulse_t pulses[$];
  pulse_t cur;
  logic   prevE = 1'b0;
  int     stableBad = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (oE && !prevE) begin
        cur.nib  = oD;
        cur.rs   = oRS;
        cur.rise = cyc;
      end else if (oE) begin
        if (oD !== cur.nib || oRS !== cur.rs) stableBad++;
      end else if (prevE) begin
        if (oD !== cur.nib || oRS !== cur.rs) stableBad++;
        cur.fall  = cyc;
        cur.width = cyc - cur.rise;
        pulses.push_back(cur);
      end
    end
    prevE = oE;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counts low-oReady negedges; dropAt>0 pulses a 0x55 write at that count.
  task automatic waitReady(input string tag, input int dropAt, output int busy, output int readyAt);
    busy = 0;
    while (oReady !== 1'b1 && busy < 5000) begin
      busy++;
      if (dropAt != 0) begin
        iWrite = (busy == dropAt);
        iRS    = 1'b1;
        iData  = 8'h55;
      end
      @(negedge clk);
    end
    if (dropAt != 0) iWrite = 1'b0;
    readyAt = cyc;
    chk(tag, oReady, 1'b1);
  endtask

  task automatic sendByte(input logic rs, input logic [7:0] data);
    iWrite = 1'b1;
    iRS    = rs;
    iData  = data;
    @(negedge clk);
    iWrite = 1'b0;
  endtask

  int busy, readyAt, n;
`ifdef LCD_INIT_EN
  logic [3:0] initExp [12] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'h6, 4'h0, 4'hC, 4'h0, 4'h1};
`endif

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", oReady, 1'b0);
    chk("rst_e", oE, 1'b0);
    chk("rst_rs", oRS, 1'b0);
    chk("rst_data", oD, 4'h0);
    chk("rst_rw", oRW, 1'b0);
    chk("rst_sf", oSF, 1'b1);
    rst = 1'b0;
    @(negedge clk);
`ifdef LCD_INIT_EN
    chk("init_ready_low", oReady, 1'b0);
    waitReady("init_done", 0, busy, readyAt);
    chk("init_count", pulses.size(), 12);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("init_nib%0d", i), pulses[i].nib, initExp[i]);
      chk($sformatf("init_rs%0d", i), pulses[i].rs, 1'b0);
    end
    chk("init_clear_wait", readyAt - pulses[11].fall, CW);
`else
    chk("ready_after_reset", oReady, 1'b1);
`endif

    // Data write 0x41 with a dropped 0x55 request while busy
    pulses.delete();
    sendByte(1'b1, 8'h41);
    waitReady("w41_ready", 10, busy, readyAt);
    chk("w41_busy", busy, 64);
    chk("w41_count", pulses.size(), 2);
    chk("w41_hi_nib", pulses[0].nib, 4'h4);
    chk("w41_hi_rs", pulses[0].rs, 1'b1);
    chk("w41_hi_width", pulses[0].width, 12);
    chk("w41_lo_nib", pulses[1].nib, 4'h1);
    chk("w41_lo_rs", pulses[1].rs, 1'b1);
    chk("w41_lo_width", pulses[1].width, 12);
    chk("w41_gap", pulses[1].rise - pulses[0].fall, NG + 2);
    chk("w41_byte_wait", readyAt - pulses[1].fall, BW);
    repeat (40) @(negedge clk);
    chk("drop_55", pulses.size(), 2);

    // Clear command uses the long wait
    pulses.delete();
    sendByte(1'b0, 8'h01);
    waitReady("c01_ready", 0, busy, readyAt);
    chk("c01_busy", busy, 94);
    chk("c01_wait", readyAt - pulses[1].fall, CW);
    chk("c01_hi_nib", pulses[0].nib, 4'h0);
    chk("c01_lo_nib", pulses[1].nib, 4'h1);
    chk("c01_rs", pulses[1].rs, 1'b0);

    // Ordinary command uses the byte wait
    pulses.delete();
    sendByte(1'b0, 8'h80);
    waitReady("c80_ready", 0, busy, readyAt);
    chk("c80_busy", busy, 64);
    chk("c80_wait", readyAt - pulses[1].fall, BW);
    chk("c80_hi_nib", pulses[0].nib, 4'h8);
    chk("c80_lo_nib", pulses[1].nib, 4'h0);

    // Reset during the high-nibble pulse
    sendByte(1'b1, 8'h41);
    n = 0;
    while (oE !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("mid_e_seen", oE, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_e", oE, 1'b0);
    chk("mid_ready", oReady, 1'b0);
    chk("mid_data", oD, 4'h0);
    chk("mid_rs", oRS, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
`ifdef LCD_INIT_EN
    waitReady("mid_reinit", 0, busy, readyAt);
`else
    chk("mid_ready_after", oReady, 1'b1);
`endif

    // Back-to-back with iWrite held high
    pulses.delete();
    iWrite = 1'b1;
    iRS    = 1'b1;
    iData  = 8'h48;
    @(negedge clk);
    chk("b2b_first_taken", oReady, 1'b0);
    iData = 8'h49;
    waitReady("b2b_ready", 0, busy, readyAt);
    chk("b2b_busy", busy, 64);
    chk("b2b_first_count", pulses.size(), 2);
    @(negedge clk);
    chk("b2b_second_taken", oReady, 1'b0);
    iWrite = 1'b0;
    waitReady("b2b_second_ready", 0, busy, readyAt);
    chk("b2b_count", pulses.size(), 4);
    chk("b2b_nib0", pulses[0].nib, 4'h4);
    chk("b2b_nib1", pulses[1].nib, 4'h8);
    chk("b2b_nib2", pulses[2].nib, 4'h4);
    chk("b2b_nib3", pulses[3].nib, 4'h9);

    chk("bus_stable", stableBad, 0);
    chk("rw_fixed", oRW, 1'b0);
    chk("sf_fixed", oSF, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
